// File: rtl/soc_input_pkg.sv
// Shared types and default configuration for the SoC input conditioning stage.
// Key debouncer state encoding plus default timing constants.
package soc_input_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_CHK,
      PRESSED,
      RELEASE_CHK
   } key_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int SYNC_STAGES_DEF     = 2;
   localparam int SW_WIDTH_DEF        = 8;

endpackage

// File: rtl/soc_input_conditioner_sync.sv
// Multi-flop synchroniser bringing an asynchronous vector into the clk_i domain.
// Every stage resets to RESET_VAL so the far side sees an idle level during reset.
module bit_synchronizer
   import soc_input_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = SYNC_STAGES_DEF,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= RESET_VAL;
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/soc_input_conditioner.sv
// Synchronises and debounces the accumulate key and conditions the switch vector.
// Optional macro SWITCH_DEBOUNCE_EN adds a stability filter on the switch vector.
module soc_input_conditioner
   import soc_input_pkg::*;
#(
   parameter int SW_WIDTH        = SW_WIDTH_DEF,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                key_accum_n,
   input  logic [SW_WIDTH-1:0] sw_raw,
   output logic                accumulate_button_export,
   output logic [SW_WIDTH-1:0] switch_wire_export,
   output logic                accum_press_pulse,
   output logic                accum_release_pulse
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                ks;
   logic [SW_WIDTH-1:0] ss;

   bit_synchronizer #(
      .WIDTH     (1),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_key_sync (
      .clk_i (clk_clk),
      .rst_i (reset_reset),
      .d_i   (key_accum_n),
      .q_o   (ks)
   );

   bit_synchronizer #(
      .WIDTH     (SW_WIDTH),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL ('0)
   ) u_sw_sync (
      .clk_i (clk_clk),
      .rst_i (reset_reset),
      .d_i   (sw_raw),
      .q_o   (ss)
   );

   key_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             button_q, button_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         button_q  <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         button_q  <= button_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // The CHK states exit on the terminal count, so cnt never needs to wrap.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      button_d  = button_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         RELEASED: begin
            if (!ks) begin
               state_d = PRESS_CHK;
               cnt_d   = '0;
            end
         end
         PRESS_CHK: begin
            if (ks) begin
               state_d = RELEASED;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = PRESSED;
               button_d = 1'b0;
               press_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (ks) begin
               state_d = RELEASE_CHK;
               cnt_d   = '0;
            end
         end
         RELEASE_CHK: begin
            if (!ks) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = RELEASED;
               button_d  = 1'b1;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
         end
      endcase
   end

   logic [SW_WIDTH-1:0] sw_q;

`ifdef SWITCH_DEBOUNCE_EN
   logic [SW_WIDTH-1:0] cand_q, cand_d, sw_d;
   logic [CNT_W-1:0]    scnt_q, scnt_d;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         cand_q <= '0;
         scnt_q <= '0;
         sw_q   <= '0;
      end else begin
         cand_q <= cand_d;
         scnt_q <= scnt_d;
         sw_q   <= sw_d;
      end
   end

   // Any bit change reloads the candidate and restarts the whole vector.
   always_comb begin
      cand_d = cand_q;
      scnt_d = scnt_q;
      sw_d   = sw_q;
      if (ss != cand_q) begin
         cand_d = ss;
         scnt_d = '0;
      end else if (scnt_q == CNT_MAX) begin
         sw_d = cand_q;
      end else begin
         scnt_d = scnt_q + CNT_W'(1);
      end
   end
`else
   // Alignment stage keeps the same timing reference as the filtered build.
   logic [SW_WIDTH-1:0] sw_stage_q;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         sw_stage_q <= '0;
         sw_q       <= '0;
      end else begin
         sw_stage_q <= ss;
         sw_q       <= sw_stage_q;
      end
   end
`endif

   assign accumulate_button_export = button_q;
   assign accum_press_pulse        = press_q;
   assign accum_release_pulse      = release_q;
   assign switch_wire_export       = sw_q;

endmodule

// File: tb/tb_soc_input_conditioner.sv
// Directed bench for soc_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Covers the default build and the SWITCH_DEBOUNCE_EN build of the switch path.
module tb_soc_input_conditioner;

   localparam int SW_W = 8;

   logic            clk_clk = 1'b0;
   logic            reset_reset;
   logic            key_accum_n;
   logic [SW_W-1:0] sw_raw;
   logic            accumulate_button_export;
   logic [SW_W-1:0] switch_wire_export;
   logic            accum_press_pulse;
   logic            accum_release_pulse;

   int checks = 0;
   int errors = 0;

   soc_input_conditioner #(
      .SW_WIDTH        (SW_W),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk_clk                  (clk_clk),
      .reset_reset              (reset_reset),
      .key_accum_n              (key_accum_n),
      .sw_raw                   (sw_raw),
      .accumulate_button_export (accumulate_button_export),
      .switch_wire_export       (switch_wire_export),
      .accum_press_pulse        (accum_press_pulse),
      .accum_release_pulse      (accum_release_pulse)
   );

   always #5 clk_clk = ~clk_clk;

   // Inputs change 1 time unit after a rising edge, so the next edge is edge 0.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_key(input string tag, input logic btn, input logic prs, input logic rel);
      check({tag, ".button"}, 32'(accumulate_button_export), 32'(btn));
      check({tag, ".press"},  32'(accum_press_pulse),        32'(prs));
      check({tag, ".release"},32'(accum_release_pulse),      32'(rel));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_reset = 1'b1;
      key_accum_n = 1'b1;
      sw_raw      = '0;
      tick(3);
      check_key("reset", 1'b1, 1'b0, 1'b0);
      check("reset.sw", 32'(switch_wire_export), 32'h0);

      reset_reset = 1'b0;
      tick(8);
      check_key("idle", 1'b1, 1'b0, 1'b0);

      // Clean press: accepted on edge 6.
      key_accum_n = 1'b0;
      tick(6);
      check_key("press.e5", 1'b1, 1'b0, 1'b0);
      tick(1);
      check_key("press.e6", 1'b0, 1'b1, 1'b0);
      tick(1);
      check_key("press.e7", 1'b0, 1'b0, 1'b0);

      // Clean release: accepted on edge 6.
      key_accum_n = 1'b1;
      tick(6);
      check_key("rel.e5", 1'b0, 1'b0, 1'b0);
      tick(1);
      check_key("rel.e6", 1'b1, 1'b0, 1'b1);
      tick(1);
      check_key("rel.e7", 1'b1, 1'b0, 1'b0);
      tick(4);

      // Bounce 0,1,0,1 then stable 0.
      for (int i = 0; i < 4; i++) begin
         key_accum_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         tick(1);
         check_key("bounce", 1'b1, 1'b0, 1'b0);
      end
      key_accum_n = 1'b0;
      tick(4);
      check_key("bounce.e3", 1'b1, 1'b0, 1'b0);
      tick(2);
      check_key("bounce.e5", 1'b1, 1'b0, 1'b0);
      tick(1);
      check_key("bounce.e6", 1'b0, 1'b1, 1'b0);

      // Reset while pressed returns outputs immediately; key stays low.
      tick(3);
      reset_reset = 1'b1;
      #1;
      check_key("rst_pressed", 1'b1, 1'b0, 1'b0);
      tick(2);
      reset_reset = 1'b0;
      tick(6);
      check_key("hold_rst.e5", 1'b1, 1'b0, 1'b0);
      tick(1);
      check_key("hold_rst.e6", 1'b0, 1'b1, 1'b0);

      key_accum_n = 1'b1;
      tick(7);
      check_key("rel2.e6", 1'b1, 1'b0, 1'b1);
      tick(3);

      // Reset while in PRESS_CHK with cnt=2 (after edge 4).
      key_accum_n = 1'b0;
      tick(5);
      reset_reset = 1'b1;
      #1;
      check_key("rst_chk", 1'b1, 1'b0, 1'b0);
      tick(3);
      check_key("rst_chk.held", 1'b1, 1'b0, 1'b0);
      reset_reset = 1'b0;
      tick(6);
      check_key("after_rst.e5", 1'b1, 1'b0, 1'b0);
      tick(1);
      check_key("after_rst.e6", 1'b0, 1'b1, 1'b0);

`ifdef SWITCH_DEBOUNCE_EN
      sw_raw = 8'hA5;
      tick(6);
      check("sw.e5", 32'(switch_wire_export), 32'h00);
      tick(1);
      check("sw.e6", 32'(switch_wire_export), 32'hA5);
      sw_raw = 8'h00;
      tick(7);
      check("sw.clr", 32'(switch_wire_export), 32'h00);
      // A5, glitch to A4 sampled at edge 3, restored at edge 4 -> update at edge 10.
      sw_raw = 8'hA5;
      tick(3);
      sw_raw = 8'hA4;
      tick(1);
      sw_raw = 8'hA5;
      tick(3);
      check("glitch.e6", 32'(switch_wire_export), 32'h00);
      tick(3);
      check("glitch.e9", 32'(switch_wire_export), 32'h00);
      tick(1);
      check("glitch.e10", 32'(switch_wire_export), 32'hA5);
`else
      sw_raw = 8'h3C;
      tick(3);
      check("sw.e2", 32'(switch_wire_export), 32'h00);
      tick(1);
      check("sw.e3", 32'(switch_wire_export), 32'h3C);
      sw_raw = 8'hC3;
      tick(3);
      check("sw2.e2", 32'(switch_wire_export), 32'h3C);
      tick(1);
      check("sw2.e3", 32'(switch_wire_export), 32'hC3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
